// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - byte delivery handshake between uart_rx and its consumer
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_overrun;
    logic       frame_err;
    logic       parity_err;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ack,
        output rx_overrun,
        output frame_err,
        output parity_err
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ack,
        input  rx_overrun,
        input  frame_err,
        input  parity_err
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ack byte delivery; UART_RX_PARITY_EN adds 8E1 parity
module uart_rx #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_pin,
    output logic [5:0] o_led,
    uart_rx_if.master  bus
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(HALF - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic        r_sync1;
    logic        r_rx_s;
    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shreg;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_rx_overrun;
    logic        r_frame_err;
    logic        w_bit_end;
    logic        w_half_end;
    logic        w_stop_good;

    assign w_bit_end  = (r_cnt == BIT_END);
    assign w_half_end = (r_cnt == HALF_END);

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;
    assign w_stop_good = (r_state == S_STOP) && w_bit_end && r_rx_s && !r_par_bad;
    assign bus.parity_err = r_parity_err;
`else
    assign w_stop_good = (r_state == S_STOP) && w_bit_end && r_rx_s;
    assign bus.parity_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= i_rx_pin;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_idx       <= 3'd0;
            r_shreg     <= 8'd0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= 16'd0;
                    end
                end
                S_START: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_half_end) begin
                        if (!r_rx_s) begin
                            r_state <= S_DATA;
                            r_cnt   <= 16'd0;
                            r_idx   <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_bit_end) begin
                        r_shreg <= {r_rx_s, r_shreg[7:1]};
                        r_cnt   <= 16'd0;
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_bit_end) begin
                        r_par_bad <= ^r_shreg ^ r_rx_s;
                        r_cnt     <= 16'd0;
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_bit_end) begin
                        r_cnt <= 16'd0;
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= r_par_bad;
`endif
                        // Returning to IDLE half a bit early lets the next start edge resync.
                        if (!r_rx_s) begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_BREAK: begin
                    if (r_rx_s) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_data    <= 8'd0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else if (w_stop_good) begin
            r_rx_data  <= r_shreg;
            r_rx_valid <= 1'b1;
            if (r_rx_valid && !bus.rx_ack)
                r_rx_overrun <= 1'b1;
            else if (r_rx_valid && bus.rx_ack)
                r_rx_overrun <= 1'b0;
        end else if (r_rx_valid && bus.rx_ack) begin
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end
    end

    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.rx_overrun = r_rx_overrun;
    assign bus.frame_err  = r_frame_err;
    assign o_led          = ~r_rx_data[5:0];
endmodule
